user_stream_accel: RTL and testbench
====================================

Name: user_stream_accel

Overview:
- Demo user-logic engine sitting directly downstream of the AHB slave's user-side interface.
- Owns the write FIFO the slave pushes into and the read FIFO the slave pops from.
- Transforms each word in a 1-stage pipeline: out = in + ADD_CONST (mod 2^32).
- Exposes control, status, checksum and constant through the slave's u_* register port.

Parameters:
- DATA_W, 32, FIFO and register data width.
- DEPTH, 8, entries per FIFO; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  single system clock (HCLK domain).
- reset  in  1  asynchronous, active-high reset.
- wrreq  in  1  slave pushes wdata into the input FIFO.
- wdata  in  DATA_W  write data.
- wrfull  out  1  input FIFO full.
- rdack  in  1  slave pops the output FIFO head.
- rdata  out  DATA_W  output FIFO head (show-ahead).
- rdempty  out  1  output FIFO empty.
- u_write  in  1  register write strobe.
- u_addr  in  32  register byte address; bits [3:2] decoded.
- u_wdata  in  DATA_W  register write data.
- u_data  out  DATA_W  register read data.

Behaviour:
- Reset:
  - Both FIFOs empty; wrfull=0; rdempty=1; rdata=0.
  - CTRL=0, CHECKSUM=0, WCOUNT=0, ADD_CONST=0; sticky flags=0; pipeline valid=0.
  - u_data reflects the reset register values.
- Register map (u_addr[3:2]):
  - 0 CTRL: bit0 ENABLE (R/W); bit1 CLEAR (write-1 self-clearing pulse, reads 0).
  - 1 STATUS (RO):
    - [CNT_W-1:0] input FIFO count.
    - [CNT_W+7:8] output FIFO count.
    - bit16 overflow sticky.
    - bit17 underflow sticky.
    - bit18 pipe_valid.
  - 2 CHECKSUM (RO): 32-bit wrapping sum of all consumed input words.
  - 3 ADD_CONST (R/W).
- u_data is combinational from u_addr (zero latency); register writes take effect on the clock edge where u_write=1.
- Write side:
  - wrreq && !wrfull pushes wdata.
  - wrreq && wrfull drops the word and sets overflow sticky.
- Read side:
  - rdata always shows the head word.
  - rdack && !rdempty pops.
  - rdack && rdempty is ignored and sets underflow sticky.
- Engine:
  - pop_in = ENABLE && input not empty && (output count + pipe_valid) < DEPTH.
  - On pop_in: stage register <= in + ADD_CONST; pipe_valid <= 1; CHECKSUM += in; WCOUNT += 1.
  - Stage pushes into the output FIFO the next cycle, so input-to-rdempty deassert latency is 2 clk.
- Sustained throughput: 1 word/clk when neither side stalls.
- ADD_CONST is sampled at pop time; a write to it never alters in-flight words.
- ENABLE=0:
  - Stops new pops.
  - An in-flight stage word still completes.
- Simultaneous push and pop on the same FIFO:
  - Both occur; count unchanged.
  - A push into a full FIFO is legal only if a pop happens the same cycle; wrfull is computed pre-pop, so the slave never does this.
- CLEAR:
  - Flushes both FIFOs and the pipeline.
  - Zeroes CHECKSUM, WCOUNT and the sticky flags.
  - Takes priority over any push, pop or register update in the same cycle; a wrreq that cycle is dropped without flagging overflow.
  - ENABLE and ADD_CONST keep their values.
- Wrap-around: FIFO pointers are log2(DEPTH) bits and wrap naturally; CHECKSUM and WCOUNT wrap mod 2^32.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); partial transfers are lost.

Optional Feature:
- Macro: USER_STREAM_ACCEL_BYTESWAP_EN.
- Defined: CTRL bit2 BSWAP (R/W) is added; when set, the stage result is byte-reversed after the add ({b0,b1,b2,b3}); CHECKSUM still sums the raw input.
- Undefined: CTRL bit2 reads 0 and writes are ignored; no swap logic is present.

Decomposition:
- Package user_stream_accel_pkg holds:
  - Register index constants: REG_CTRL=0, REG_STATUS=1, REG_CSUM=2, REG_CONST=3.
  - CTRL bit positions (ENABLE=0, CLEAR=1, BSWAP=2).
  - STATUS field offsets.
- Sub-module user_sync_fifo:
  - Parameterized DATA_W/DEPTH, show-ahead.
  - Ports: clk, reset, clear, push, wdata, pop, rdata, full, empty, count.
  - Instantiated twice.

Test Plan:
- Reset release, no stimulus -> rdempty=1, wrfull=0, STATUS reads 0, CHECKSUM reads 0.
- ADD_CONST=0x10, ENABLE=1, push 0x1,0x2,0x3 -> output 0x11,0x12,0x13 in order; CHECKSUM=0x6; first rdempty=0 exactly 2 clk after first push.
- ENABLE=0, push 9 words with DEPTH=8 -> wrfull=1 after 8; 9th dropped; STATUS bit16=1, input count=8.
- ENABLE=1, rdack held low -> engine fills the output FIFO to 8 and stalls; input count stays at 0 (DEPTH=8, 8 words already queued); no data loss or reorder after draining with rdack.
- rdack with rdempty=1 -> underflow sticky set; then write CTRL=0x3 (CLEAR) -> counts, CHECKSUM and stickies zero; ENABLE stays 1.
- Push 0xFFFFFFFF then 0x2 -> CHECKSUM=0x1 (wrap); with BYTESWAP_EN, BSWAP=1, ADD_CONST=0, push 0x11223344 -> rdata=0x44332211.

Source files
------------

// File: rtl/user_stream_accel_pkg.sv
// ---------------------------------------------------------------------------
// user_stream_accel_pkg
//   Shared constants for the user-side stream engine: register indices
//   (decoded from u_addr[3:2]), CTRL bit positions and STATUS field offsets.
//   Optional feature macro used by importers: USER_STREAM_ACCEL_BYTESWAP_EN.
// ---------------------------------------------------------------------------
package user_stream_accel_pkg;

  typedef logic [1:0] reg_idx_t;

  // Register indices (word address within the 16-byte window)
  localparam reg_idx_t REG_CTRL   = 2'd0;
  localparam reg_idx_t REG_STATUS = 2'd1;
  localparam reg_idx_t REG_CSUM   = 2'd2;
  localparam reg_idx_t REG_CONST  = 2'd3;

  // CTRL bit positions
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_BSWAP  = 2;

  // STATUS field offsets
  localparam int STAT_IN_CNT     = 0;
  localparam int STAT_OUT_CNT    = 8;
  localparam int STAT_OVERFLOW   = 16;
  localparam int STAT_UNDERFLOW  = 17;
  localparam int STAT_PIPE_VALID = 18;

endpackage

// File: rtl/user_sync_fifo.sv
// ---------------------------------------------------------------------------
// user_sync_fifo
//   Single-clock show-ahead FIFO. rdata always presents the head word (0 when
//   empty). A push while full is accepted only if a pop happens in the same
//   cycle. clear flushes the FIFO and beats any push/pop in that cycle.
// Ports:
//   clk, reset (async, active-high), clear (sync flush)
//   push/wdata  - enqueue
//   pop         - dequeue head (ignored when empty)
//   rdata       - head word
//   full, empty, count - occupancy
// ---------------------------------------------------------------------------
module user_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is tracked by count/pointers, and
  // rdata is forced to 0 while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/user_stream_accel.sv
// ---------------------------------------------------------------------------
// user_stream_accel
//   Demo user-logic engine behind the AHB slave user interface. Words pushed
//   into the input FIFO are moved through a one-stage pipeline
//   (out = in + ADD_CONST) into the output FIFO the slave reads from.
//   Optional feature macro: USER_STREAM_ACCEL_BYTESWAP_EN adds CTRL bit2 BSWAP,
//   which byte-reverses the stage result after the add.
// Ports:
//   clk, reset (async, active-high)
//   wrreq/wdata/wrfull  - input FIFO write side
//   rdack/rdata/rdempty - output FIFO read side (show-ahead)
//   u_write/u_addr/u_wdata/u_data - register port (u_addr[3:2] decoded,
//                                   zero-latency read)
// ---------------------------------------------------------------------------
module user_stream_accel
  import user_stream_accel_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrreq,
  input  logic [DATA_W-1:0] wdata,
  output logic              wrfull,
  input  logic              rdack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdempty,
  input  logic              u_write,
  input  logic [31:0]       u_addr,
  input  logic [DATA_W-1:0] u_wdata,
  output logic [DATA_W-1:0] u_data
);

  reg_idx_t          reg_idx;
  logic              ctrl_wr;
  logic              const_wr;
  logic              clear;

  logic              enable;
  logic [DATA_W-1:0] add_const;
  logic [DATA_W-1:0] checksum;
  logic [31:0]       wcount;
  logic              overflow;
  logic              underflow;
  logic              pipe_valid;
  logic [DATA_W-1:0] stage_data;

  logic              in_push;
  logic [DATA_W-1:0] in_rdata;
  logic              in_full;
  logic              in_empty;
  logic [CNT_W-1:0]  in_count;
  logic              out_empty;
  logic [CNT_W-1:0]  out_count;

  logic [CNT_W:0]    out_occ;
  logic              pop_in;
  logic [DATA_W-1:0] stage_sum;
  logic [DATA_W-1:0] stage_next;

`ifdef USER_STREAM_ACCEL_BYTESWAP_EN
  logic              bswap;
  logic [DATA_W-1:0] stage_swapped;
`endif

  assign reg_idx  = u_addr[3:2];
  assign ctrl_wr  = u_write && (reg_idx == REG_CTRL);
  assign const_wr = u_write && (reg_idx == REG_CONST);
  assign clear    = ctrl_wr && u_wdata[CTRL_CLEAR];

  // A write dropped by CLEAR is not an overflow, so gate the push here rather
  // than relying on the FIFO's own clear priority.
  assign in_push = wrreq && !in_full && !clear;

  // Output space must also cover the word sitting in the stage register.
  assign out_occ = {1'b0, out_count} + (CNT_W + 1)'(pipe_valid);
  assign pop_in  = enable && !in_empty && !clear &&
                   (out_occ < (CNT_W + 1)'(DEPTH));

  user_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (in_push),
    .wdata (wdata),
    .pop   (pop_in),
    .rdata (in_rdata),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  user_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (pipe_valid),
    .wdata (stage_data),
    .pop   (rdack),
    .rdata (rdata),
    .full  (),
    .empty (out_empty),
    .count (out_count)
  );

  assign wrfull    = in_full;
  assign rdempty   = out_empty;
  assign stage_sum = in_rdata + add_const;

`ifdef USER_STREAM_ACCEL_BYTESWAP_EN
  // Byte b of the result takes byte (N-1-b) of the sum.
  always_comb begin
    stage_swapped = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      stage_swapped[8*b +: 8] = stage_sum[DATA_W-8-8*b +: 8];
    end
  end
  assign stage_next = bswap ? stage_swapped : stage_sum;
`else
  assign stage_next = stage_sum;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable     <= 1'b0;
      add_const  <= '0;
      checksum   <= '0;
      wcount     <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      pipe_valid <= 1'b0;
      stage_data <= '0;
`ifdef USER_STREAM_ACCEL_BYTESWAP_EN
      bswap      <= 1'b0;
`endif
    end else if (clear) begin
      // ENABLE, BSWAP and ADD_CONST deliberately survive a CLEAR.
      checksum   <= '0;
      wcount     <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      pipe_valid <= 1'b0;
    end else begin
      // The stage word is handed to the output FIFO every cycle it is valid,
      // so valid simply follows pop_in.
      pipe_valid <= pop_in;
      if (pop_in) begin
        stage_data <= stage_next;
        checksum   <= checksum + in_rdata;
        wcount     <= wcount + 32'd1;
      end
      if (wrreq && in_full)    overflow  <= 1'b1;
      if (rdack && out_empty)  underflow <= 1'b1;
      if (ctrl_wr) begin
        enable <= u_wdata[CTRL_ENABLE];
`ifdef USER_STREAM_ACCEL_BYTESWAP_EN
        bswap  <= u_wdata[CTRL_BSWAP];
`endif
      end
      if (const_wr) add_const <= u_wdata;
    end
  end

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    u_data = '0;
    case (reg_idx)
      REG_CTRL: begin
        u_data[CTRL_ENABLE] = enable;
`ifdef USER_STREAM_ACCEL_BYTESWAP_EN
        u_data[CTRL_BSWAP]  = bswap;
`endif
      end
      REG_STATUS: begin
        u_data[STAT_IN_CNT +: CNT_W]  = in_count;
        u_data[STAT_OUT_CNT +: CNT_W] = out_count;
        u_data[STAT_OVERFLOW]         = overflow;
        u_data[STAT_UNDERFLOW]        = underflow;
        u_data[STAT_PIPE_VALID]       = pipe_valid;
      end
      REG_CSUM:  u_data = checksum;
      REG_CONST: u_data = add_const;
      default:   u_data = '0;
    endcase
  end

  // WCOUNT is internal bookkeeping with no register window; the upper and
  // byte-offset address bits are not decoded.
  logic unused_bits;
  assign unused_bits = ^{u_addr[31:4], u_addr[1:0], wcount};

endmodule

// File: tb/tb_user_stream_accel.sv
// ---------------------------------------------------------------------------
// tb_user_stream_accel
//   Self-checking bench for user_stream_accel (DEPTH=8, DATA_W=32).
//   Register-map vectors from a table, hand sequences for latency / full /
//   stall / underflow / clear / wrap / async reset, and a randomized phase
//   checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_user_stream_accel;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wrreq;
  logic [31:0] wdata;
  logic        wrfull;
  logic        rdack;
  logic [31:0] rdata;
  logic        rdempty;
  logic        u_write;
  logic [31:0] u_addr;
  logic [31:0] u_wdata;
  logic [31:0] u_data;

  always #5 clk = ~clk;

  user_stream_accel dut (
    .clk     (clk),
    .reset   (reset),
    .wrreq   (wrreq),
    .wdata   (wdata),
    .wrfull  (wrfull),
    .rdack   (rdack),
    .rdata   (rdata),
    .rdempty (rdempty),
    .u_write (u_write),
    .u_addr  (u_addr),
    .u_wdata (u_wdata),
    .u_data  (u_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (queues, spec-level rules) -------------
  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  bit          st_v;
  logic [31:0] st_d;
  bit          m_en, m_bs, m_ovf, m_udf;
  logic [31:0] m_const, m_csum;

  task automatic model_reset();
    in_q.delete(); out_q.delete();
    st_v = 0; st_d = 0; m_en = 0; m_bs = 0; m_ovf = 0; m_udf = 0;
    m_const = 0; m_csum = 0;
  endtask

  function automatic logic [31:0] swap_bytes(input logic [31:0] x);
    return ((x & 32'h0000_00FF) << 24) | ((x & 32'h0000_FF00) << 8) |
           ((x & 32'h00FF_0000) >> 8)  | ((x & 32'hFF00_0000) >> 24);
  endfunction

  function automatic logic [31:0] model_reg(input logic [1:0] idx);
    case (idx)
      2'd0:    return (32'(m_bs) << 2) | 32'(m_en);
      2'd1:    return 32'(in_q.size()) | (32'(out_q.size()) << 8) |
                      (32'(m_ovf) << 16) | (32'(m_udf) << 17) | (32'(st_v) << 18);
      2'd2:    return m_csum;
      default: return m_const;
    endcase
  endfunction

  // One clock: drive inputs, advance the model, clock, compare FIFO outputs.
  task automatic tick(input logic wr, input logic [31:0] wd, input logic ack,
                      input logic uw, input logic [1:0] uidx, input logic [31:0] uwd);
    bit          clr, push_ok, pop_out, pop_in;
    logic [31:0] head;
    wrreq = wr; wdata = wd; rdack = ack;
    u_write = uw; u_addr = {28'h0, uidx, 2'b00}; u_wdata = uwd;
    clr = uw && (uidx == 2'd0) && uwd[1];
    if (clr) begin
      in_q.delete(); out_q.delete();
      st_v = 0; m_csum = 0; m_ovf = 0; m_udf = 0;
    end else begin
      push_ok = wr && (in_q.size() < DEPTH);
      pop_out = ack && (out_q.size() > 0);
      pop_in  = m_en && (in_q.size() > 0) && (out_q.size() + int'(st_v) < DEPTH);
      if (wr && !push_ok)  m_ovf = 1;
      if (ack && !pop_out) m_udf = 1;
      if (pop_out) void'(out_q.pop_front());
      if (st_v) out_q.push_back(st_d);
      st_v = pop_in;
      if (pop_in) begin
        head   = in_q.pop_front();
        st_d   = m_bs ? swap_bytes(head + m_const) : head + m_const;
        m_csum = m_csum + head;
      end
      if (push_ok) in_q.push_back(wd);
      if (uw && uidx == 2'd0) begin
        m_en = uwd[0];
`ifdef USER_STREAM_ACCEL_BYTESWAP_EN
        m_bs = uwd[2];
`endif
      end
      if (uw && uidx == 2'd3) m_const = uwd;
    end
    @(posedge clk);
    #1;
    wrreq = 1'b0; rdack = 1'b0; u_write = 1'b0;
    check("rdempty", 32'(rdempty), 32'(out_q.size() == 0));
    check("wrfull",  32'(wrfull),  32'(in_q.size() == DEPTH));
    check("rdata",   rdata, (out_q.size() > 0) ? out_q[0] : 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask
  task automatic push_word(input logic [31:0] w);  tick(1, w, 0, 0, 0, 0); endtask
  task automatic pop_word();                        tick(0, 0, 1, 0, 0, 0); endtask
  task automatic wr_reg(input logic [1:0] idx, input logic [31:0] d); tick(0, 0, 0, 1, idx, d); endtask

  task automatic rd_reg(input logic [1:0] idx, output logic [31:0] d);
    u_addr = {28'h0, idx, 2'b00};
    #1;
    d = u_data;
  endtask

  // ---------------- register-map vectors ------------------------------------
  typedef struct {
    string       name;
    bit          wr;
    logic [1:0]  idx;
    logic [31:0] wd;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t    vecs[11];
  logic [31:0] rv;
  logic [31:0] exp_words[11];
  int          pwr, pack, r;
  logic [31:0] cw;

  initial begin
    reset = 1'b1; wrreq = 0; wdata = 0; rdack = 0;
    u_write = 0; u_addr = 0; u_wdata = 0;
    model_reset();
    #12;
    @(posedge clk); #1;
    reset = 1'b0;

    check("rst_rdempty", 32'(rdempty), 32'h1);
    check("rst_wrfull",  32'(wrfull),  32'h0);
    check("rst_rdata",   rdata,        32'h0);

    vecs[0]  = '{"rst_ctrl",        0, 2'd0, 32'h0,         32'h0};
    vecs[1]  = '{"rst_status",      0, 2'd1, 32'h0,         32'h0};
    vecs[2]  = '{"rst_csum",        0, 2'd2, 32'h0,         32'h0};
    vecs[3]  = '{"rst_const",       0, 2'd3, 32'h0,         32'h0};
    vecs[4]  = '{"const_rw",        1, 2'd3, 32'hDEADBEEF,  32'hDEADBEEF};
    vecs[5]  = '{"ctrl_enable",     1, 2'd0, 32'h1,         32'h1};
`ifdef USER_STREAM_ACCEL_BYTESWAP_EN
    vecs[6]  = '{"ctrl_bswap",      1, 2'd0, 32'h5,         32'h5};
`else
    vecs[6]  = '{"ctrl_bit2_absent",1, 2'd0, 32'h5,         32'h1};
`endif
    vecs[7]  = '{"ctrl_upper_ign",  1, 2'd0, 32'hFFFF_FFF8, 32'h0};
    vecs[8]  = '{"status_ro",       1, 2'd1, 32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{"csum_ro",         1, 2'd2, 32'h0000_1234, 32'h0};
    vecs[10] = '{"const_zero",      1, 2'd3, 32'h0,         32'h0};

    foreach (vecs[i]) begin
      if (vecs[i].wr) wr_reg(vecs[i].idx, vecs[i].wd);
      rd_reg(vecs[i].idx, rv);
      check(vecs[i].name, rv, vecs[i].exp);
    end

    // ---- basic transform and 2-cycle latency ----
    wr_reg(2'd3, 32'h10);
    wr_reg(2'd0, 32'h1);
    push_word(32'h1); check("lat_e0_empty", 32'(rdempty), 32'h1);
    push_word(32'h2); check("lat_e1_empty", 32'(rdempty), 32'h1);
    push_word(32'h3); check("lat_e2_ready", 32'(rdempty), 32'h0);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      check("basic_out", rdata, 32'h11 + 32'(i));
      pop_word();
    end
    rd_reg(2'd2, rv); check("basic_csum", rv, 32'h6);

    // ---- fill input FIFO with engine stopped ----
    wr_reg(2'd0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      push_word(32'h100 + 32'(i));
      if (i == 6) check("fill_not_full", 32'(wrfull), 32'h0);
      if (i == 7) check("fill_full",     32'(wrfull), 32'h1);
    end
    rd_reg(2'd1, rv); check("ovf_status", rv, 32'h0001_0008);

    // ---- engine stalls on full output FIFO, then drain in order ----
    wr_reg(2'd0, 32'h1);
    idle(12);
    rd_reg(2'd1, rv); check("stall_status", rv, 32'h0001_0800);
    for (int j = 0; j < 3; j++) push_word(32'h200 + 32'(j));
    idle(4);
    rd_reg(2'd1, rv); check("stall_more", rv, 32'h0001_0803);
    for (int i = 0; i < 11; i++)
      exp_words[i] = ((i < 8) ? 32'h100 + 32'(i) : 32'h200 + 32'(i - 8)) + 32'h10;
    for (int i = 0; i < 11; i++) begin
      check("drain_order", rdata, exp_words[i]);
      pop_word();
    end
    idle(4);
    rd_reg(2'd1, rv); check("drained_status", rv, 32'h0001_0000);

    // ---- underflow, then CLEAR ----
    pop_word();
    rd_reg(2'd1, rv); check("udf_status", rv, 32'h0003_0000);
    push_word(32'h55);
    wr_reg(2'd0, 32'h3);
    rd_reg(2'd1, rv); check("clr_status", rv, 32'h0);
    rd_reg(2'd2, rv); check("clr_csum",   rv, 32'h0);
    rd_reg(2'd0, rv); check("clr_ctrl",   rv, 32'h1);
    rd_reg(2'd3, rv); check("clr_const",  rv, 32'h10);

    // ---- checksum wrap ----
    wr_reg(2'd3, 32'h0);
    push_word(32'hFFFF_FFFF);
    push_word(32'h2);
    idle(3);
    rd_reg(2'd2, rv); check("csum_wrap", rv, 32'h1);
    check("wrap_out0", rdata, 32'hFFFF_FFFF); pop_word();
    check("wrap_out1", rdata, 32'h2);         pop_word();

`ifdef USER_STREAM_ACCEL_BYTESWAP_EN
    wr_reg(2'd0, 32'h5);
    push_word(32'h1122_3344);
    idle(2);
    check("bswap_out", rdata, 32'h4433_2211);
    pop_word();
    rd_reg(2'd2, rv); check("bswap_csum_raw", rv, 32'h1122_3345);
    wr_reg(2'd0, 32'h1);
`endif

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 600; i++) begin
      case (i / 150)
        0:       begin pwr = 90; pack = 20; end
        1:       begin pwr = 20; pack = 90; end
        2:       begin pwr = 60; pack = 60; end
        default: begin pwr = 90; pack = 90; end
      endcase
      r = int'($urandom_range(31));
      if (r == 0)
        tick($urandom_range(99) < pwr, $urandom, $urandom_range(99) < pack, 1, 2'd3, $urandom);
      else if (r == 1) begin
        cw = {29'h0, 1'($urandom_range(1)), 1'b0, 1'($urandom_range(3) != 0)};
        tick($urandom_range(99) < pwr, $urandom, $urandom_range(99) < pack, 1, 2'd0, cw);
      end else
        tick($urandom_range(99) < pwr, $urandom, $urandom_range(99) < pack, 0, 2'd0, 0);
      if (i % 20 == 0) begin
        rd_reg(2'd1, rv); check("rand_status", rv, model_reg(2'd1));
        rd_reg(2'd2, rv); check("rand_csum",   rv, model_reg(2'd2));
        rd_reg(2'd0, rv); check("rand_ctrl",   rv, model_reg(2'd0));
      end
    end

    // ---- asynchronous reset mid-stream ----
    wr_reg(2'd0, 32'h1);
    for (int i = 0; i < 5; i++) push_word(32'hA0 + 32'(i));
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("arst_rdempty", 32'(rdempty), 32'h1);
    check("arst_wrfull",  32'(wrfull),  32'h0);
    rd_reg(2'd1, rv); check("arst_status", rv, 32'h0);
    rd_reg(2'd0, rv); check("arst_ctrl",   rv, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(3);
    rd_reg(2'd2, rv); check("arst_csum", rv, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
